// File: rtl/sipo_deserializer.sv
// LSB-first serial-in/parallel-out receiver with a valid/ready output register.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per frame.
module sipo_deserializer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic             bit_en,
    input  logic             sof,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    input  logic             d_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef PARITY_CHECK_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    logic [FRAME-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cur_cnt;
    logic             done, accept, load;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        cur_cnt = cnt_q;
        done    = 1'b0;
        if (bit_en) begin
            shift_d = {s_in, shift_q[FRAME-1:1]};
            // sof with a sampled bit makes that bit position 0 of a fresh frame
            cur_cnt = sof ? '0 : cnt_q;
            if (cur_cnt == LAST) begin
                done  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cur_cnt + 1'b1;
            end
        end else if (sof) begin
            cnt_d = '0;
        end
        accept = d_valid & d_ready;
        load   = done & (~d_valid | d_ready);
    end

    assign busy = (cnt_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            if (load) begin
                d_out   <= shift_d[WIDTH-1:0];
                d_valid <= 1'b1;
            end else if (accept) begin
                d_valid <= 1'b0;
            end
            if (done && d_valid && !d_ready) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic perr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else if (load) begin
            perr_q <= ^shift_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: directed frames plus random traffic
// checked against a bit-list reference model.
module tb_sipo_deserializer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk;
    logic             reset;
    logic             s_in;
    logic             bit_en;
    logic             sof;
    logic [WIDTH-1:0] d_out;
    logic             d_valid;
    logic             d_ready;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    sipo_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_in      (s_in),
        .bit_en    (bit_en),
        .sof       (sof),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .busy      (busy),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WIDTH-1:0] w;
        logic             pe;
    } exp_t;

    exp_t exp_q[$];
    bit   m_bits[$];
    bit   m_pend = 1'b0;
    bit   m_ovr  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame = list of sampled bits; a word is delivered
    // unless an earlier word is still waiting and not taken this edge.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_bits.delete();
                exp_q.delete();
                m_pend = 1'b0;
                m_ovr  = 1'b0;
            end else begin
                bit taken;
                taken = m_pend && d_ready;
                if (taken) m_pend = 1'b0;
                if (bit_en) begin
                    if (sof) m_bits.delete();
                    m_bits.push_back(s_in);
                    if (m_bits.size() == FRAME) begin
                        exp_t e;
                        e.w  = '0;
                        e.pe = 1'b0;
                        for (int k = 0; k < WIDTH; k++) e.w += WIDTH'(m_bits[k]) << k;
`ifdef PARITY_CHECK_EN
                        for (int k = 0; k < FRAME; k++) e.pe ^= m_bits[k];
`endif
                        m_bits.delete();
                        if (m_pend) begin
                            m_ovr = 1'b1;
                        end else begin
                            exp_q.push_back(e);
                            m_pend = 1'b1;
                        end
                    end
                end else if (sof) begin
                    m_bits.delete();
                end
            end
        end
    end

    // Monitor: compare at the falling edge, pop on handshake.
    always @(negedge clk) begin
        chk("d_valid", 32'(d_valid), 32'(m_pend));
        chk("busy", 32'(busy), 32'(m_bits.size() != 0));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (d_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL word: got unexpected word %0h, required none", d_out);
            end else begin
                chk("d_out", 32'(d_out), 32'(exp_q[0].w));
                chk("parity_err", 32'(parity_err), 32'(exp_q[0].pe));
                if (d_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic step(input bit en, input bit s, input bit sf, input bit rdy);
        bit_en  = en;
        s_in    = s;
        sof     = sf;
        d_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input bit sof_first, input int gaps,
                              input bit bad_par, input bit rdy_last);
        for (int i = 0; i < FRAME; i++) begin
            bit b;
            if (i > 0) repeat (gaps) step(1'b0, 1'b0, 1'b0, 1'b0);
            b = (i < WIDTH) ? w[i] : ((^w) ^ bad_par);
            step(1'b1, b, sof_first && (i == 0), (i == FRAME - 1) ? rdy_last : 1'b0);
        end
    endtask

    // Called at edge+2: reset low at +3, released at +7, realigned to edge+2.
    task automatic pulse_reset(input bit check);
        #1 reset = 1'b0;
        #1;
        if (check) begin
            chk("rst d_out", 32'(d_out), 32'd0);
            chk("rst d_valid", 32'(d_valid), 32'd0);
            chk("rst busy", 32'(busy), 32'd0);
            chk("rst overrun", 32'(overrun), 32'd0);
            chk("rst parity_err", 32'(parity_err), 32'd0);
        end
        #3 reset = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset   = 1'b1;
        s_in    = 1'b0;
        bit_en  = 1'b0;
        sof     = 1'b0;
        d_ready = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("init d_valid", 32'(d_valid), 32'd0);
        chk("init d_out", 32'(d_out), 32'd0);
        repeat (2) @(posedge clk);
        #7 reset = 1'b1;
        @(posedge clk);
        #2;

        // Basic frame, latency and handshake
        send_frame(4'b1101, 1'b1, 0, 1'b0, 1'b0);
        chk("basic valid", 32'(d_valid), 32'd1);
        chk("basic d_out", 32'(d_out), 32'hD);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic consumed", 32'(d_valid), 32'd0);

        // Idle gaps between sampled bits
        send_frame(4'b0010, 1'b1, 2, 1'b0, 1'b0);
        chk("gaps d_out", 32'(d_out), 32'h2);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Resync: abandon two bits, restart on sof
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("resync busy", 32'(busy), 32'd1);
        chk("resync no word", 32'(d_valid), 32'd0);
        send_frame(4'b1110, 1'b1, 0, 1'b0, 1'b0);
        chk("resync d_out", 32'(d_out), 32'hE);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("resync single", 32'(d_valid), 32'd0);

        // Overrun: second word dropped while first pending
        send_frame(4'hA, 1'b1, 0, 1'b0, 1'b0);
        send_frame(4'h5, 1'b1, 0, 1'b0, 1'b0);
        chk("ovr d_out", 32'(d_out), 32'hA);
        chk("ovr flag", 32'(overrun), 32'd1);

        // Async reset mid-frame
        step(1'b1, 1'b1, 1'b1, 1'b0);
        pulse_reset(1'b1);

        // Completion on the handshake edge: new word replaces old, no overrun
        send_frame(4'hA, 1'b1, 0, 1'b0, 1'b0);
        send_frame(4'h5, 1'b1, 0, 1'b0, 1'b1);
        chk("swap d_out", 32'(d_out), 32'h5);
        chk("swap valid", 32'(d_valid), 32'd1);
        chk("swap overrun", 32'(overrun), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_CHECK_EN
        send_frame(4'b0111, 1'b1, 0, 1'b0, 1'b0);
        chk("par ok err", 32'(parity_err), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(4'b0111, 1'b1, 0, 1'b1, 1'b0);
        chk("par bad err", 32'(parity_err), 32'd1);
        chk("par bad d_out", 32'(d_out), 32'h7);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Random traffic with occasional resets
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset(1'b0);
            end else begin
                step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 2) != 0));
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
